// File: rtl/hpc_csr_if.sv
// HPC bus (Avalon-MM subset) between a bus master and the CSR bank.
// Ports / signals:
//   address        word address, ADDR_W bits
//   read, write    single-cycle strobes; no waitrequest
//   writedata      32-bit write data
//   byteenable     per-byte write enable (ignored on reads)
//   readdata       registered read data from the slave
//   readdatavalid  one-cycle qualifier for readdata
interface hpc_csr_if #(
  parameter int unsigned ADDR_W = 5
);
  logic [ADDR_W-1:0] address;
  logic              read;
  logic              write;
  logic [31:0]       writedata;
  logic [3:0]        byteenable;
  logic [31:0]       readdata;
  logic              readdatavalid;

  modport master (
    output address, read, write, writedata, byteenable,
    input  readdata, readdatavalid
  );

  modport slave (
    input  address, read, write, writedata, byteenable,
    output readdata, readdatavalid
  );
endinterface

// File: rtl/hpc_csr_bank.sv
// Control/status register bank on the HPC bus.
// Holds NUM_CTRL byte-writable control words, a self-clearing pulse register,
// NUM_STAT status words behind a freezable shadow, a version/config ID and a
// saturating counter of read/write collisions.
// Ports:
//   clk      single clock, all logic on posedge
//   reset    synchronous, active-low
//   slave    hpc_csr_if slave modport (address/read/write/writedata/byteenable,
//            readdata/readdatavalid)
//   o_ctrl   control words, ctrl[k] on bits [32k+31:32k]
//   o_pulse  one-cycle pulses from writes to PULSE
//   i_stat   status inputs, same packing as o_ctrl
module hpc_csr_bank #(
  parameter int unsigned SYS_VERSION = 20,
  parameter int unsigned ADDR_W      = 5,
  parameter int unsigned NUM_CTRL    = 2,
  parameter int unsigned NUM_STAT    = 4,
  parameter int unsigned CTRL_BASE   = 8,
  parameter int unsigned STAT_BASE   = 16,
  parameter logic [31:0] CTRL_RST    = 32'h0
) (
  input  logic                     clk,
  input  logic                     reset,
  hpc_csr_if.slave                 slave,
  output logic [NUM_CTRL*32-1:0]   o_ctrl,
  output logic [31:0]              o_pulse,
  input  logic [NUM_STAT*32-1:0]   i_stat
);

  localparam logic [ADDR_W-1:0] A_VERSION = ADDR_W'(0);
  localparam logic [ADDR_W-1:0] A_CONFIG  = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] A_PULSE   = ADDR_W'(2);
  localparam logic [ADDR_W-1:0] A_SNAP    = ADDR_W'(3);
  localparam logic [ADDR_W-1:0] A_ERR     = ADDR_W'(4);

  logic [31:0]         ctrl_q   [NUM_CTRL];
  logic [31:0]         shadow_q [NUM_STAT];
  logic                hold_q;
  logic [15:0]         err_cnt_q;
  logic [31:0]         pulse_q;
  logic [31:0]         rdata_q;
  logic                rvalid_q;

  logic                collision;
  logic                wr_en;
  logic                err_flag;
  logic [31:0]         wmask;
  logic [31:0]         rd_mux;
  logic [NUM_CTRL-1:0] ctrl_sel;

  // A simultaneous read and write is a bus error: the read proceeds, the write is dropped.
  assign collision = slave.read & slave.write;
  assign wr_en     = slave.write & ~slave.read;
  assign err_flag  = (err_cnt_q != 16'h0);
  assign wmask     = {{8{slave.byteenable[3]}}, {8{slave.byteenable[2]}},
                      {8{slave.byteenable[1]}}, {8{slave.byteenable[0]}}};

  // Read mux and ctrl word decode. Unmapped addresses (including PULSE) read as zero.
  always_comb begin
    rd_mux   = 32'h0;
    ctrl_sel = '0;
    case (slave.address)
      A_VERSION: rd_mux = 32'(SYS_VERSION);
      A_CONFIG:  rd_mux = {8'h0, 8'(ADDR_W), 8'(NUM_CTRL), 8'(NUM_STAT)};
      A_SNAP:    rd_mux = {30'h0, err_flag, hold_q};
      A_ERR:     rd_mux = {16'h0, err_cnt_q};
      default:   rd_mux = 32'h0;
    endcase
    for (int k = 0; k < int'(NUM_CTRL); k++) begin
      if (slave.address == ADDR_W'(CTRL_BASE + 32'(k))) begin
        rd_mux      = ctrl_q[k];
        ctrl_sel[k] = 1'b1;
      end
    end
    for (int k = 0; k < int'(NUM_STAT); k++) begin
      if (slave.address == ADDR_W'(STAT_BASE + 32'(k))) begin
        rd_mux = shadow_q[k];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int k = 0; k < int'(NUM_CTRL); k++) ctrl_q[k] <= CTRL_RST;
      for (int k = 0; k < int'(NUM_STAT); k++) shadow_q[k] <= 32'h0;
      hold_q    <= 1'b0;
      err_cnt_q <= 16'h0;
      pulse_q   <= 32'h0;
      rdata_q   <= 32'h0;
      rvalid_q  <= 1'b0;
    end else begin
      rvalid_q <= slave.read;
      if (slave.read) rdata_q <= rd_mux;

      pulse_q <= 32'h0;
      if (wr_en && slave.address == A_PULSE) pulse_q <= slave.writedata & wmask;
      if (wr_en && slave.address == A_SNAP)  hold_q  <= slave.writedata[0];

      for (int k = 0; k < int'(NUM_CTRL); k++) begin
        if (wr_en && ctrl_sel[k])
          ctrl_q[k] <= (ctrl_q[k] & ~wmask) | (slave.writedata & wmask);
      end

      // hold is still 0 during the SNAP=1 write cycle, so that cycle's inputs are the ones frozen.
      if (!hold_q) begin
        for (int k = 0; k < int'(NUM_STAT); k++) shadow_q[k] <= i_stat[32*k +: 32];
      end

      if (collision) begin
        if (err_cnt_q != 16'hFFFF) err_cnt_q <= err_cnt_q + 16'h1;
      end else if (wr_en && slave.address == A_ERR) begin
        err_cnt_q <= 16'h0;
      end
    end
  end

  for (genvar g = 0; g < int'(NUM_CTRL); g++) begin : g_ctrl_out
    assign o_ctrl[32*g +: 32] = ctrl_q[g];
  end

  assign o_pulse             = pulse_q;
  assign slave.readdata      = rdata_q;
  assign slave.readdatavalid = rvalid_q;

endmodule
